// File: rtl/cpu_obi_port_arbiter.sv
// Shares one OBI slave port between the core's instruction and data masters,
// with round-robin tie breaking, stall locking and in-order response routing.
package cpu_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module cpu_obi_port_arbiter
  import cpu_obi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          DATA_FIRST      = 1'b1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  core_instr_req_i,
  output obi_resp_t core_instr_resp_o,
  input  obi_req_t  core_data_req_i,
  output obi_resp_t core_data_resp_o,
  output obi_req_t  mem_req_o,
  input  obi_resp_t mem_resp_i,
  output logic      idle_o,
  output logic      unexpected_rsp_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PW-1:0]              head_q;
  logic [PW-1:0]              tail_q;
  logic [CW-1:0]              count_q;
  logic                       last_data_q;
  logic                       lock_q;
  logic                       lock_sel_q;

  logic any_req;
  logic both_req;
  logic sel_data;
  logic full;
  logic empty;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  endfunction

  // A stalled request keeps ownership of the port until the slave grants it.
  always_comb begin
    any_req  = core_instr_req_i.req | core_data_req_i.req;
    both_req = core_instr_req_i.req & core_data_req_i.req;
    full     = (count_q == COUNT_MAX);
    empty    = (count_q == '0);
    if (lock_q) begin
      sel_data = lock_sel_q;
    end else if (both_req) begin
      sel_data = ~last_data_q;
    end else begin
      sel_data = core_data_req_i.req;
    end
  end

  always_comb begin
    mem_req_o = '0;
    if (any_req) begin
      mem_req_o = sel_data ? core_data_req_i : core_instr_req_i;
    end
    mem_req_o.req = any_req & ~full;
    push = mem_req_o.req & mem_resp_i.gnt;
    pop  = mem_resp_i.rvalid & ~empty;
  end

  // Responses return in issue order, so the FIFO head names their owner.
  always_comb begin
    core_instr_resp_o.rdata  = mem_resp_i.rdata;
    core_data_resp_o.rdata   = mem_resp_i.rdata;
    core_instr_resp_o.gnt    = rst_ni & push & ~sel_data;
    core_data_resp_o.gnt     = rst_ni & push & sel_data;
    core_instr_resp_o.rvalid = rst_ni & pop & ~owner_q[head_q];
    core_data_resp_o.rvalid  = rst_ni & pop & owner_q[head_q];
    unexpected_rsp_o         = rst_ni & mem_resp_i.rvalid & empty;
    idle_o                   = empty & ~any_req;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        owner_q[tail_q] <= sel_data;
        tail_q          <= ptr_next(tail_q);
      end
      if (pop) begin
        head_q <= ptr_next(head_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // last_data_q records the previous winner; resetting it to the instruction
  // side lets the data master win the first tie when DATA_FIRST is set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_data_q <= !DATA_FIRST;
      lock_q      <= 1'b0;
      lock_sel_q  <= 1'b0;
    end else begin
      if (push) begin
        last_data_q <= sel_data;
      end
      lock_q <= mem_req_o.req & ~mem_resp_i.gnt;
      if (mem_req_o.req) begin
        lock_sel_q <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_obi_port_arbiter.sv
// Self-checking bench for cpu_obi_port_arbiter: directed scenarios with a
// queue of expected response owners that is drained as rvalids are driven.
module tb_cpu_obi_port_arbiter;
  import cpu_obi_pkg::*;

  logic      clk;
  logic      rst_ni;
  obi_req_t  instr_req;
  obi_req_t  data_req;
  obi_req_t  mem_req;
  obi_resp_t instr_resp;
  obi_resp_t data_resp;
  obi_resp_t mem_resp;
  logic      idle;
  logic      unexp;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  bit last_was_data;

  cpu_obi_port_arbiter #(
    .MAX_OUTSTANDING(2),
    .DATA_FIRST     (1'b1)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .core_instr_req_i (instr_req),
    .core_instr_resp_o(instr_resp),
    .core_data_req_i  (data_req),
    .core_data_resp_o (data_resp),
    .mem_req_o        (mem_req),
    .mem_resp_i       (mem_resp),
    .idle_o           (idle),
    .unexpected_rsp_o (unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    instr_req = '0;
    data_req  = '0;
    mem_resp  = '0;
  endtask

  function automatic obi_req_t mk_req(input logic [31:0] addr);
    obi_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.be    = 4'hF;
    r.addr  = addr;
    r.wdata = ~addr;
    return r;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    exp_q.delete();
    last_was_data = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    mem_resp.rvalid = 1'b1;
    settle();
    checks++; if (instr_resp.gnt !== 1'b0 || data_resp.gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b%b expected 00", instr_resp.gnt, data_resp.gnt); end
    checks++; if (instr_resp.rvalid !== 1'b0 || data_resp.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b%b expected 00", instr_resp.rvalid, data_resp.rvalid); end
    checks++; if (unexp !== 1'b0) begin errors++; $display("[TB] FAIL reset_unexp: got %b expected 0", unexp); end
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (mem_req !== '0) begin errors++; $display("[TB] FAIL reset_mem_req: got %h expected 0", mem_req); end
    tick();
    mem_resp.rvalid = 1'b0;
    rst_ni = 1'b1;
    last_was_data = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bit exp_owner;
    data_req = mk_req(32'h100);
    mem_resp.gnt = 1'b1;
    settle();
    checks++; if (mem_req.req !== 1'b1 || mem_req.addr !== 32'h100) begin errors++; $display("[TB] FAIL single_mem_req: got req=%b addr=%h expected req=1 addr=100", mem_req.req, mem_req.addr); end
    checks++; if (data_resp.gnt !== 1'b1 || instr_resp.gnt !== 1'b0) begin errors++; $display("[TB] FAIL single_gnt: got d=%b i=%b expected d=1 i=0", data_resp.gnt, instr_resp.gnt); end
    exp_q.push_back(1'b1);
    last_was_data = 1'b1;
    tick();
    clear_inputs();
    settle();
    checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL single_busy: got idle=%b expected 0", idle); end
    tick();
    mem_resp.rvalid = 1'b1;
    mem_resp.rdata  = 32'hCAFEF00D;
    settle();
    exp_owner = exp_q.pop_front();
    checks++; if (data_resp.rvalid !== exp_owner || instr_resp.rvalid !== !exp_owner) begin errors++; $display("[TB] FAIL single_rvalid: got d=%b i=%b expected d=%b i=%b", data_resp.rvalid, instr_resp.rvalid, exp_owner, !exp_owner); end
    checks++; if (data_resp.rdata !== 32'hCAFEF00D || instr_resp.rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL single_rdata: got d=%h i=%h expected cafef00d", data_resp.rdata, instr_resp.rdata); end
    tick();
    clear_inputs();
    settle();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL single_idle: got %b expected 1", idle); end
    tick();
  endtask

  task automatic test_tie();
    bit exp_owner;
    bit exp_sel;
    logic [31:0] exp_addr;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      instr_req = mk_req(32'h2000 + 32'(k * 4));
      data_req  = mk_req(32'h3000 + 32'(k * 4));
      if (k == 4) begin
        instr_req = '0;
        data_req  = '0;
      end
      mem_resp.gnt    = 1'b1;
      mem_resp.rvalid = (k >= 1);
      mem_resp.rdata  = 32'h1000 + 32'(k);
      settle();
      if (k >= 1) begin
        exp_owner = exp_q.pop_front();
        checks++; if (data_resp.rvalid !== exp_owner || instr_resp.rvalid !== !exp_owner) begin errors++; $display("[TB] FAIL tie_rvalid[%0d]: got d=%b i=%b expected d=%b i=%b", k, data_resp.rvalid, instr_resp.rvalid, exp_owner, !exp_owner); end
      end
      if (k < 4) begin
        exp_sel  = !last_was_data;
        exp_addr = exp_sel ? 32'h3000 + 32'(k * 4) : 32'h2000 + 32'(k * 4);
        checks++; if (data_resp.gnt !== exp_sel || instr_resp.gnt !== !exp_sel) begin errors++; $display("[TB] FAIL tie_gnt[%0d]: got d=%b i=%b expected d=%b i=%b", k, data_resp.gnt, instr_resp.gnt, exp_sel, !exp_sel); end
        checks++; if (mem_req.addr !== exp_addr) begin errors++; $display("[TB] FAIL tie_addr[%0d]: got %h expected %h", k, mem_req.addr, exp_addr); end
        exp_q.push_back(exp_sel);
        last_was_data = exp_sel;
      end
      tick();
    end
    clear_inputs();
    settle();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL tie_idle: got %b expected 1", idle); end
    tick();
  endtask

  task automatic test_lock();
    bit exp_owner;
    bit exp_sel;
    logic [31:0] exp_addr;
    instr_req = mk_req(32'h4000);
    for (int k = 0; k < 6; k++) begin
      if (k >= 3) data_req = mk_req(32'h5000);
      if (k == 5) instr_req = '0;
      mem_resp.gnt = (k >= 4);
      settle();
      exp_sel  = (k == 5);
      exp_addr = exp_sel ? 32'h5000 : 32'h4000;
      checks++; if (mem_req.addr !== exp_addr || mem_req.req !== 1'b1) begin errors++; $display("[TB] FAIL lock_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", k, mem_req.req, mem_req.addr, exp_addr); end
      checks++; if (instr_resp.gnt !== (k == 4) || data_resp.gnt !== (k == 5)) begin errors++; $display("[TB] FAIL lock_gnt[%0d]: got i=%b d=%b expected i=%b d=%b", k, instr_resp.gnt, data_resp.gnt, (k == 4), (k == 5)); end
      if (k >= 4) begin
        exp_q.push_back(exp_sel);
        last_was_data = exp_sel;
      end
      tick();
    end
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      mem_resp.rvalid = 1'b1;
      mem_resp.rdata  = 32'h4400 + 32'(k);
      settle();
      exp_owner = exp_q.pop_front();
      checks++; if (data_resp.rvalid !== exp_owner || instr_resp.rvalid !== !exp_owner) begin errors++; $display("[TB] FAIL lock_rvalid[%0d]: got d=%b i=%b expected d=%b i=%b", k, data_resp.rvalid, instr_resp.rvalid, exp_owner, !exp_owner); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_full();
    bit exp_owner;
    for (int k = 0; k < 4; k++) begin
      data_req        = mk_req(32'h6000 + 32'(k * 4));
      mem_resp.gnt    = 1'b1;
      mem_resp.rvalid = (k == 2);
      mem_resp.rdata  = 32'h6666;
      settle();
      if (k == 2) begin
        checks++; if (mem_req.req !== 1'b0 || data_resp.gnt !== 1'b0) begin errors++; $display("[TB] FAIL full_block: got req=%b gnt=%b expected 0 0", mem_req.req, data_resp.gnt); end
        exp_owner = exp_q.pop_front();
        checks++; if (data_resp.rvalid !== exp_owner) begin errors++; $display("[TB] FAIL full_rvalid: got %b expected %b", data_resp.rvalid, exp_owner); end
      end else begin
        checks++; if (mem_req.req !== 1'b1 || data_resp.gnt !== 1'b1) begin errors++; $display("[TB] FAIL full_accept[%0d]: got req=%b gnt=%b expected 1 1", k, mem_req.req, data_resp.gnt); end
        exp_q.push_back(1'b1);
        last_was_data = 1'b1;
      end
      tick();
    end
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      mem_resp.rvalid = 1'b1;
      settle();
      exp_owner = exp_q.pop_front();
      checks++; if (data_resp.rvalid !== exp_owner || instr_resp.rvalid !== !exp_owner) begin errors++; $display("[TB] FAIL full_drain[%0d]: got d=%b i=%b expected d=%b i=%b", k, data_resp.rvalid, instr_resp.rvalid, exp_owner, !exp_owner); end
      tick();
    end
    clear_inputs();
    settle();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL full_idle: got %b expected 1", idle); end
    tick();
  endtask

  task automatic test_spurious();
    bit exp_owner;
    mem_resp.rvalid = 1'b1;
    mem_resp.rdata  = 32'hDEAD0000;
    settle();
    checks++; if (unexp !== 1'b1) begin errors++; $display("[TB] FAIL spur_pulse: got %b expected 1", unexp); end
    checks++; if (instr_resp.rvalid !== 1'b0 || data_resp.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL spur_rvalid: got i=%b d=%b expected 0 0", instr_resp.rvalid, data_resp.rvalid); end
    tick();
    clear_inputs();
    instr_req    = mk_req(32'h7000);
    mem_resp.gnt = 1'b1;
    settle();
    checks++; if (unexp !== 1'b0) begin errors++; $display("[TB] FAIL spur_clear: got %b expected 0", unexp); end
    checks++; if (instr_resp.gnt !== 1'b1 || data_resp.gnt !== 1'b0) begin errors++; $display("[TB] FAIL spur_gnt: got i=%b d=%b expected 1 0", instr_resp.gnt, data_resp.gnt); end
    exp_q.push_back(1'b0);
    last_was_data = 1'b0;
    tick();
    clear_inputs();
    mem_resp.rvalid = 1'b1;
    mem_resp.rdata  = 32'h7777;
    settle();
    exp_owner = exp_q.pop_front();
    checks++; if (instr_resp.rvalid !== !exp_owner || data_resp.rvalid !== exp_owner || unexp !== 1'b0) begin errors++; $display("[TB] FAIL spur_legal: got i=%b d=%b unexp=%b expected i=%b d=%b unexp=0", instr_resp.rvalid, data_resp.rvalid, unexp, !exp_owner, exp_owner); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bit exp_owner;
    instr_req    = mk_req(32'h8000);
    mem_resp.gnt = 1'b1;
    settle();
    checks++; if (instr_resp.gnt !== 1'b1) begin errors++; $display("[TB] FAIL rmid_gnt0: got %b expected 1", instr_resp.gnt); end
    tick();
    instr_req = '0;
    data_req  = mk_req(32'h9000);
    settle();
    checks++; if (data_resp.gnt !== 1'b1) begin errors++; $display("[TB] FAIL rmid_gnt1: got %b expected 1", data_resp.gnt); end
    tick();
    instr_req       = mk_req(32'h8004);
    data_req        = mk_req(32'h9004);
    mem_resp.gnt    = 1'b1;
    mem_resp.rvalid = 1'b1;
    #1;
    rst_ni = 1'b0;
    exp_q.delete();
    last_was_data = 1'b0;
    settle();
    checks++; if (instr_resp.gnt !== 1'b0 || data_resp.gnt !== 1'b0) begin errors++; $display("[TB] FAIL rmid_gnt: got i=%b d=%b expected 0 0", instr_resp.gnt, data_resp.gnt); end
    checks++; if (instr_resp.rvalid !== 1'b0 || data_resp.rvalid !== 1'b0 || unexp !== 1'b0) begin errors++; $display("[TB] FAIL rmid_rvalid: got i=%b d=%b unexp=%b expected 0 0 0", instr_resp.rvalid, data_resp.rvalid, unexp); end
    checks++; if (mem_req.req !== 1'b1) begin errors++; $display("[TB] FAIL rmid_req: got %b expected 1", mem_req.req); end
    tick();
    clear_inputs();
    settle();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL rmid_idle_rst: got %b expected 1", idle); end
    tick();
    rst_ni = 1'b1;
    settle();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL rmid_idle: got %b expected 1", idle); end
    tick();
    instr_req    = mk_req(32'hA000);
    data_req     = mk_req(32'hB000);
    mem_resp.gnt = 1'b1;
    settle();
    checks++; if (data_resp.gnt !== !last_was_data || instr_resp.gnt !== last_was_data) begin errors++; $display("[TB] FAIL rmid_tie: got d=%b i=%b expected d=%b i=%b", data_resp.gnt, instr_resp.gnt, !last_was_data, last_was_data); end
    exp_q.push_back(!last_was_data);
    last_was_data = 1'b1;
    tick();
    clear_inputs();
    mem_resp.rvalid = 1'b1;
    settle();
    exp_owner = exp_q.pop_front();
    checks++; if (data_resp.rvalid !== exp_owner || instr_resp.rvalid !== !exp_owner) begin errors++; $display("[TB] FAIL rmid_rvalid_post: got d=%b i=%b expected d=%b i=%b", data_resp.rvalid, instr_resp.rvalid, exp_owner, !exp_owner); end
    tick();
    clear_inputs();
    settle();
    checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL rmid_idle_end: got %b expected 1", idle); end
    tick();
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    last_was_data = 1'b0;
    tick();
    test_reset();
    test_single_read();
    test_tie();
    test_lock();
    test_full();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
